// File: rtl/cpc_rom_slot_mapper.sv
// ---------------------------------------------------------------------------
// cpc_rom_slot_mapper
//
// Expansion-ROM slot manager for the CPC core. It steers ioctl download bytes
// into SDRAM pages chosen by the image's two-character hex file extension. It
// keeps a per-slot "loaded" bitmap. It also masks CPU reads of upper-ROM slots
// that are either unloaded or hidden.
//
// Ports
//   clk_sys         in   system clock
//   reset           in   synchronous, active-high reset
//   ioctl_download  in   download in progress
//   ioctl_index     in   [7:0]  0 = system ROM set (ignored), else expansion image
//   ioctl_wr        in   byte strobe (level, one byte per high phase)
//   ioctl_addr      in   [24:0] byte offset within the image
//   ioctl_dout      in   [7:0]  byte data
//   ioctl_file_ext  in   [15:8] first / [7:0] second extension character
//   map_clear       in   one-cycle pulse, clears the loaded bitmap
//   mask_slot_en    in   hide MASK_SLOT from the CPU
//   ram_a           in   [22:0] CPU address, bit 22 = upper-ROM space
//   boot_wr         out  SDRAM write strobe (one clock after ioctl_wr)
//   boot_a          out  [22:0] SDRAM byte address {page, offset[13:0]}
//   boot_dout       out  [7:0]  SDRAM write data
//   rom_mask        out  1 = suppress SDRAM read (CPU sees FFh)
//   busy            out  1 while an expansion download is being captured
// ---------------------------------------------------------------------------
module cpc_rom_slot_mapper #(
  parameter int         SLOTS       = 256,
  parameter int         COMBO_SLOTS = 1,
  parameter logic [8:0] SYS_PAGE    = 9'h1FF,
  parameter logic [8:0] BAD_PAGE    = 9'h1EE,
  parameter logic [7:0] MASK_SLOT   = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] ioctl_file_ext,
  input  logic        map_clear,
  input  logic        mask_slot_en,
  input  logic [22:0] ram_a,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [7:0]  boot_dout,
  output logic        rom_mask,
  output logic        busy
);

  localparam int         IDXW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [7:0] SLOT_MASK = 8'(SLOTS - 1);

  // DISCARD captures malformed-extension images into BAD_PAGE with no bitmap update.
  typedef enum logic [1:0] {IDLE, LOAD, COMBO, DISCARD} mode_t;

  mode_t            mode;
  logic [7:0]       base;
  logic             dl_q;
  logic             wr_q;
  logic [7:0]       wr_slot_q;
  logic             wr_mark_q;
  logic [SLOTS-1:0] loaded;
  logic [SLOTS-1:0] loaded_nxt;

  // Returns {valid, value} for an uppercase ASCII hex digit.
  function automatic logic [4:0] hex_nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
    if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    return 5'b0;
  endfunction

  // Extension decode, evaluated when a download starts.
  logic [4:0] hi_nib, lo_nib;
  mode_t      start_mode;
  logic [7:0] start_base;

  assign hi_nib = hex_nib(ioctl_file_ext[15:8]);
  assign lo_nib = hex_nib(ioctl_file_ext[7:0]);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    start_mode = DISCARD;
    start_base = 8'h00;
    if (hi_nib[4] && lo_nib[4]) begin
      start_mode = LOAD;
      start_base = {hi_nib[3:0], lo_nib[3:0]};
    end else if (ioctl_file_ext == 16'h5A5A) begin      // "ZZ"
      start_mode = LOAD;
    end else if (ioctl_file_ext == 16'h5A30) begin      // "Z0"
      start_mode = COMBO;
    end
  end

  // Per-byte page selection for the current mode.
  logic [7:0]  load_slot;
  logic [7:0]  combo_slot;
  logic [10:0] combo_blk;
  logic        wr_ok;
  logic        wr_mark;
  logic [7:0]  wr_slot;
  logic [8:0]  wr_page;

  assign load_slot  = (base + ioctl_addr[21:14]) & SLOT_MASK;  // 8-bit add wraps past the last slot
  assign combo_slot = ioctl_addr[21:14] & SLOT_MASK;
  assign combo_blk  = ioctl_addr[24:14];

  always_comb begin
    wr_ok   = 1'b0;
    wr_mark = 1'b0;
    wr_slot = load_slot;
    wr_page = BAD_PAGE;
    case (mode)
      LOAD: begin
        if (ioctl_addr[24:22] == 3'd0) begin
          wr_ok   = 1'b1;
          wr_mark = 1'b1;
          wr_page = {1'b1, load_slot};
        end
      end
      COMBO: begin
        if (combo_blk < 11'(COMBO_SLOTS)) begin
          wr_ok   = 1'b1;
          wr_mark = 1'b1;
          wr_slot = combo_slot;
          wr_page = {1'b1, combo_slot};
        end else if (combo_blk == 11'(COMBO_SLOTS)) begin
          wr_ok   = 1'b1;
          wr_page = SYS_PAGE;
        end
      end
      DISCARD: wr_ok = 1'b1;   // BAD_PAGE verbatim, offset never added
      default: ;
    endcase
  end

  // CPU read-side slot lookup.
  logic [7:0] rd_slot;
  assign rd_slot = ram_a[21:14] & SLOT_MASK;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode      <= IDLE;
      base      <= 8'h00;
      dl_q      <= 1'b1;   // download still high after reset must not look like a new start
      wr_q      <= 1'b0;
      wr_slot_q <= 8'h00;
      wr_mark_q <= 1'b0;
      boot_wr   <= 1'b0;
      boot_a    <= 23'h0;
      boot_dout <= 8'h00;
      rom_mask  <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      wr_q <= ioctl_wr;

      if (!ioctl_download) begin
        mode <= IDLE;
      end else if (!dl_q && ioctl_index != 8'd0) begin
        mode <= start_mode;
        base <= start_base;
      end

      boot_wr   <= ioctl_wr & wr_ok;
      boot_a    <= {wr_page, ioctl_addr[13:0]};
      boot_dout <= ioctl_dout;

      // Remember the slot of the byte in flight; it is marked when the strobe falls.
      if (ioctl_wr) begin
        wr_slot_q <= wr_slot;
        wr_mark_q <= wr_mark;
      end

      rom_mask <= ram_a[22] & (~loaded[rd_slot[IDXW-1:0]] |
                               (mask_slot_en & (rd_slot == MASK_SLOT)));
    end
  end

  // A set on the falling strobe wins over a simultaneous clear for that slot.
  always_comb begin
    loaded_nxt = map_clear ? '0 : loaded;
    if (!reset && wr_q && !ioctl_wr && wr_mark_q)
      loaded_nxt[wr_slot_q[IDXW-1:0]] = 1'b1;
  end

  // NOTE: the bitmap survives reset on purpose; only map_clear empties it.
  always_ff @(posedge clk_sys) begin
    loaded <= loaded_nxt;
  end

  assign busy = (mode != IDLE);

  logic unused_ram_low;
  assign unused_ram_low = &{1'b0, ram_a[13:0]};

endmodule

// File: tb/tb_cpc_rom_slot_mapper.sv
module tb_cpc_rom_slot_mapper;

  localparam int SLOTS       = 256;
  localparam int COMBO_SLOTS = 1;
  localparam int SYS_PAGE    = 'h1FF;
  localparam int BAD_PAGE    = 'h1EE;
  localparam int MASK_SLOT   = 'hFF;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] ioctl_file_ext;
  logic        map_clear;
  logic        mask_slot_en;
  logic [22:0] ram_a;
  logic        boot_wr;
  logic [22:0] boot_a;
  logic [7:0]  boot_dout;
  logic        rom_mask;
  logic        busy;

  cpc_rom_slot_mapper #(
    .SLOTS(SLOTS), .COMBO_SLOTS(COMBO_SLOTS),
    .SYS_PAGE(9'h1FF), .BAD_PAGE(9'h1EE), .MASK_SLOT(8'hFF)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_file_ext(ioctl_file_ext), .map_clear(map_clear),
    .mask_slot_en(mask_slot_en), .ram_a(ram_a),
    .boot_wr(boot_wr), .boot_a(boot_a), .boot_dout(boot_dout),
    .rom_mask(rom_mask), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model: mode kind 0 idle, 1 good load, 2 bad extension, 3 combo.
  int          m_kind = 0;
  int          m_base = 0;
  bit          m_loaded[SLOTS];
  bit          prev_wr = 0;
  int          last_slot = 0;
  bit          last_mark = 0;
  int          pulses = 0;
  bit          seen_first = 0;
  logic [22:0] first_a = '0;
  logic [22:0] last_a = '0;

  function automatic int nib(input logic [7:0] c);
    if (c >= 8'd48 && c <= 8'd57) return int'(c) - 48;
    if (c >= 8'd65 && c <= 8'd70) return int'(c) - 55;
    return -1;
  endfunction

  function automatic void predict(input int addr, output bit ew, output int ea,
                                  output int slot, output bit mk);
    int blk, off, page;
    ew = 0; ea = 0; slot = 0; mk = 0; page = 0;
    blk = addr / 16384;
    off = addr % 16384;
    case (m_kind)
      1: if (blk < 256) begin slot = (m_base + blk) % SLOTS; page = 256 + slot; ew = 1; mk = 1; end
      2: begin page = BAD_PAGE; ew = 1; end
      3: begin
        if (blk < COMBO_SLOTS) begin slot = blk % SLOTS; page = 256 + slot; ew = 1; mk = 1; end
        else if (blk == COMBO_SLOTS) begin page = SYS_PAGE; ew = 1; end
      end
      default: ;
    endcase
    ea = page * 16384 + off;
  endfunction

  // One clock: drive the byte interface, predict, check the registered write port.
  task automatic step(input bit wr, input int addr, input string tag);
    bit ew, mk;
    int ea, slot;
    logic [7:0] d;
    d = 8'($urandom);
    ioctl_wr = wr; ioctl_addr = 25'(addr); ioctl_dout = d;
    predict(addr, ew, ea, slot, mk);
    ew = ew & wr & !reset;
    if (map_clear) foreach (m_loaded[i]) m_loaded[i] = 0;
    if (!reset && prev_wr && !wr && last_mark) m_loaded[last_slot] = 1;
    if (wr && !reset) begin last_slot = slot; last_mark = mk; end
    prev_wr = wr & !reset;
    if (reset) m_kind = 0;
    @(posedge clk_sys); #1;
    total++;
    if (boot_wr !== ew || (ew && (boot_a !== 23'(ea) || boot_dout !== d))) begin
      bad++;
      $display("FAIL %s write@%h: boot_wr=%b boot_a=%h boot_dout=%h, expected wr=%b a=%h d=%h",
               tag, addr, boot_wr, boot_a, boot_dout, ew, 23'(ea), d);
    end
    if (boot_wr === 1'b1) begin
      pulses++;
      if (!seen_first) first_a = boot_a;
      seen_first = 1;
      last_a = boot_a;
    end
  endtask

  task automatic check_mask(input int slot, input bit upper, input string tag);
    bit exp;
    ram_a = {upper, 8'(slot), 14'($urandom)};
    exp = upper && (!m_loaded[slot] || (mask_slot_en && slot == MASK_SLOT));
    step(0, int'(ioctl_addr), tag);
    total++;
    if (rom_mask !== exp) begin
      bad++;
      $display("FAIL %s rom_mask slot=%0d upper=%b: got %b, expected %b", tag, slot, upper, rom_mask, exp);
    end
  endtask

  task automatic scan_all(input string tag);
    for (int s = 0; s < SLOTS; s++) check_mask(s, 1, tag);
    check_mask(int'($urandom_range(0, 255)), 0, tag);
  endtask

  task automatic pulse_clear();
    map_clear = 1;
    step(0, int'(ioctl_addr), "clear");
    map_clear = 0;
  endtask

  task automatic send_run(input int start, input int len, input string tag);
    for (int i = 0; i < len; i++) step(1, start + i, tag);
    step(0, start + len - 1, tag);
  endtask

  // Sparse image: head, a random middle run and the tail of every 16 KB block.
  task automatic load_blocks(input int first_blk, input int nblk, input string tag);
    for (int b = first_blk; b < first_blk + nblk; b++) begin
      send_run(b * 16384, 32, tag);
      send_run(b * 16384 + 32 + int'($urandom_range(0, 16384 - 96)), 32, tag);
      send_run(b * 16384 + 16384 - 32, 32, tag);
    end
  endtask

  task automatic start_dl(input logic [7:0] index, input logic [15:0] ext, input string tag);
    int hi, lo;
    ioctl_download = 1; ioctl_index = index; ioctl_file_ext = ext;
    step(0, 0, tag);
    if (index != 0) begin
      hi = nib(ext[15:8]); lo = nib(ext[7:0]);
      if (hi >= 0 && lo >= 0) begin m_kind = 1; m_base = hi * 16 + lo; end
      else if (ext == 16'h5A5A) begin m_kind = 1; m_base = 0; end
      else if (ext == 16'h5A30) begin m_kind = 3; m_base = 0; end
      else m_kind = 2;
    end
    total++;
    if (busy !== (index != 0)) begin
      bad++;
      $display("FAIL %s busy at start: got %b, expected %b", tag, busy, index != 0);
    end
    pulses = 0; seen_first = 0;
  endtask

  task automatic end_dl(input string tag);
    ioctl_download = 0;
    step(0, int'(ioctl_addr), tag);
    m_kind = 0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy after end: got %b, expected 0", tag, busy); end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s: got %h, expected %h", tag, got, exp); end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step(0, 0, "reset");
    total++;
    if (boot_wr !== 1'b0 || busy !== 1'b0 || rom_mask !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs: wr=%b busy=%b mask=%b, expected 0 0 0", boot_wr, busy, rom_mask);
    end
    reset = 0;
    pulse_clear();
    scan_all("reset_scan");
  endtask

  task automatic test_ext07();
    start_dl(8'd1, 16'h3037, "ext07");
    load_blocks(0, 2, "ext07");
    end_dl("ext07");
    expect_val("ext07 first boot_a", 32'(first_a), 32'h41C000);
    expect_val("ext07 last boot_a", 32'(last_a), 32'h423FFF);
    expect_val("ext07 pulses", pulses, 192);
    check_mask(7, 1, "ext07"); check_mask(8, 1, "ext07");
    check_mask(6, 1, "ext07"); check_mask(9, 1, "ext07");
  endtask

  task automatic test_ext_fe();
    start_dl(8'd2, 16'h4645, "extFE");
    load_blocks(0, 3, "extFE");
    end_dl("extFE");
    expect_val("extFE first boot_a", 32'(first_a), 32'h7F8000);
    expect_val("extFE wrapped last boot_a", 32'(last_a), 32'h403FFF);
    check_mask(0, 1, "extFE ram_a=400000");
    check_mask(5, 1, "extFE ram_a=414000");
  endtask

  task automatic test_combo();
    pulse_clear();
    start_dl(8'd3, 16'h5A30, "combo");
    load_blocks(0, 3, "combo");
    end_dl("combo");
    expect_val("combo pulses", pulses, 192);
    expect_val("combo last boot_a", 32'(last_a), 32'h7FFFFF);
    scan_all("combo_scan");
  endtask

  task automatic test_bad_ext();
    start_dl(8'd4, 16'h7121, "bad_ext");
    load_blocks(0, 1, "bad_ext");
    send_run(5 * 16384 + 100, 8, "bad_ext");
    end_dl("bad_ext");
    expect_val("bad_ext last page", 32'(last_a[22:14]), 32'h1EE);
    scan_all("bad_scan");
  endtask

  task automatic test_index0();
    start_dl(8'd0, 16'h3037, "index0");
    send_run(0, 16, "index0");
    end_dl("index0");
    expect_val("index0 pulses", pulses, 0);
  endtask

  task automatic test_mask_slot();
    start_dl(8'd5, 16'h4646, "extFF");
    load_blocks(0, 1, "extFF");
    end_dl("extFF");
    mask_slot_en = 1;
    check_mask(255, 1, "mask_en=1");
    check_mask(254, 1, "mask_en=1 other");
    check_mask(255, 0, "mask_en=1 lower");
    mask_slot_en = 0;
    check_mask(255, 1, "mask_en=0");
  endtask

  // Back-to-back downloads with random extensions, including dropped high addresses.
  task automatic test_random();
    logic [15:0] ext;
    int v;
    for (int it = 0; it < 6; it++) begin
      v = int'($urandom_range(0, 15)); ext[15:8] = 8'(v < 10 ? 48 + v : 55 + v);
      v = int'($urandom_range(0, 15)); ext[7:0]  = 8'(v < 10 ? 48 + v : 55 + v);
      start_dl(8'($urandom_range(1, 255)), ext, "random");
      load_blocks(int'($urandom_range(0, 3)), int'($urandom_range(1, 2)), "random");
      send_run((256 + int'($urandom_range(0, 500))) * 16384 + 7, 4, "random_drop");
      end_dl("random");
    end
    scan_all("random_scan");
  endtask

  task automatic test_clear_set_same_cycle();
    start_dl(8'd6, 16'h3230, "clr_set");
    for (int i = 0; i < 8; i++) step(1, i, "clr_set");
    map_clear = 1;
    step(0, 7, "clr_set");
    map_clear = 0;
    end_dl("clr_set");
    scan_all("clr_set_scan");
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    start_dl(8'd7, 16'h3033, "reset_mid");
    load_blocks(0, 1, "reset_mid");
    for (int i = 0; i < 16; i++) step(1, 'h4E10 + i, "reset_mid");
    reset = 1;
    step(1, 'h4E20, "reset_mid hit");
    expect_val("reset_mid busy", 32'(busy), 0);
    reset = 0;
    send_run('h4E30, 8, "reset_mid after");
    expect_val("reset_mid busy still low", 32'(busy), 0);
    end_dl("reset_mid");
    check_mask(3, 1, "reset_mid slot3");
    check_mask(4, 1, "reset_mid slot4");
    pulse_clear();
    scan_all("reset_mid_clear");
  endtask

  initial begin
    reset = 1; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
    ioctl_addr = 0; ioctl_dout = 0; ioctl_file_ext = 0;
    map_clear = 0; mask_slot_en = 0; ram_a = 0;
    test_reset();
    test_ext07();
    test_ext_fe();
    test_combo();
    test_bad_ext();
    test_index0();
    test_mask_slot();
    test_random();
    test_clear_set_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
